// File: rtl/spi_pkg.sv
// Shared SPI slave types, constants and the spi_clk edge decoder.
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef struct packed {
        logic sample;
        logic shift;
    } spi_strobe_t;

    localparam int unsigned SPI_SYNC_STAGES = 2;

    // Leading edge leaves the idle level, trailing edge returns to it.
    function automatic spi_strobe_t spi_edge_decode(input logic prev, input logic cur,
                                                    input logic cpol, input logic cpha);
        spi_strobe_t s;
        logic leading;
        logic trailing;
        leading  = (prev == cpol) && (cur != cpol);
        trailing = (prev != cpol) && (cur == cpol);
        s.sample = cpha ? trailing : leading;
        s.shift  = cpha ? leading : trailing;
        return s;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous ready/valid FIFO for received SPI words; drops pushes when full.
module spi_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             drop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = !empty && pop_ready;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && !do_push;
    assign pop_valid = !empty;
    assign pop_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave with TX holding register and RX FIFO, all in the clk domain.
// Define SPI_LSB_FIRST_EN to shift both directions LSB first.
module spi_slave_stream
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned CPOL     = 0,
    parameter int unsigned CPHA     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_clk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    output logic             underrun,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam spi_mode_t MODE = '{cpol: 1'(CPOL), cpha: 1'(CPHA)};

    logic [SPI_SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
    logic sclk_prev, csn_prev, sclk_s, csn_s, mosi_s;
    logic cs_fall, cs_rise, sample, shift, word_done, word_start;
    spi_strobe_t strobe;

    logic             frame_active, tx_full, tx_pend, push, fifo_drop;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-2:0] shift_rx;
    logic [WIDTH-1:0] shift_tx, tx_hold, rx_word, tx_next, push_data;

    // cs_n flops reset to "asserted" so a frame already running at reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SPI_SYNC_STAGES{MODE.cpol}};
            sclk_prev <= MODE.cpol;
            csn_sync  <= '0;
            csn_prev  <= 1'b0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SPI_SYNC_STAGES-2:0], spi_clk};
            csn_sync  <= {csn_sync[SPI_SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SPI_SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            csn_prev  <= csn_s;
        end
    end

    assign sclk_s  = sclk_sync[SPI_SYNC_STAGES-1];
    assign csn_s   = csn_sync[SPI_SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SPI_SYNC_STAGES-1];
    assign strobe  = spi_edge_decode(sclk_prev, sclk_s, MODE.cpol, MODE.cpha);
    assign cs_fall = csn_prev & ~csn_s;
    assign cs_rise = ~csn_prev & csn_s;
    assign sample  = frame_active & ~cs_rise & strobe.sample;
    assign shift   = frame_active & ~cs_rise & strobe.shift;

`ifdef SPI_LSB_FIRST_EN
    assign rx_word = {mosi_s, shift_rx};
    assign tx_next = {1'b0, shift_tx[WIDTH-1:1]};
    assign miso    = frame_active & shift_tx[0];
`else
    assign rx_word = {shift_rx, mosi_s};
    assign tx_next = {shift_tx[WIDTH-2:0], 1'b0};
    assign miso    = frame_active & shift_tx[WIDTH-1];
`endif

    assign word_done  = sample && (bit_cnt == CW'(WIDTH - 1));
    assign word_start = (cs_fall && !MODE.cpha) || (shift && (bit_cnt == '0));
    assign tx_ready   = ~tx_full;
    assign busy       = frame_active;

    // The cs_n-fall load only peeks at the holding register; it is consumed on the
    // first sampled bit so an empty frame leaves the held word in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_active <= 1'b0;
            bit_cnt      <= '0;
            shift_rx     <= '0;
            shift_tx     <= '0;
            tx_hold      <= '0;
            tx_full      <= 1'b0;
            tx_pend      <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
            push         <= 1'b0;
            push_data    <= '0;
        end else begin
            push <= word_done;
            if (word_done) push_data <= rx_word;
            if (fifo_drop) overrun <= 1'b1;
            if (tx_valid && tx_ready) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end
            if (cs_rise) begin
                frame_active <= 1'b0;
                bit_cnt      <= '0;
                tx_pend      <= 1'b0;
            end else if (cs_fall) begin
                frame_active <= 1'b1;
                bit_cnt      <= '0;
            end else if (sample) begin
`ifdef SPI_LSB_FIRST_EN
                shift_rx <= rx_word[WIDTH-1:1];
`else
                shift_rx <= rx_word[WIDTH-2:0];
`endif
                bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
                if (tx_pend) begin
                    tx_full <= 1'b0;
                    tx_pend <= 1'b0;
                end
            end
            if (word_start) begin
                shift_tx <= tx_full ? tx_hold : '0;
                if (!tx_full) underrun <= 1'b1;
                else if (cs_fall) tx_pend <= 1'b1;
                else tx_full <= 1'b0;
            end else if (shift) begin
                shift_tx <= tx_next;
            end
        end
    end

    spi_rx_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .full     (),
        .drop     (fifo_drop),
        .pop_data (rx_data),
        .pop_valid(rx_valid),
        .pop_ready(rx_ready)
    );

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench: mode 0 / 8-bit and mode 3 / 16-bit instances of spi_slave_stream.
`timescale 1ns/1ps
module tb_spi_slave_stream;

    localparam int HALF = 40;

    typedef struct {
        logic [7:0] mosi_word;
        logic [7:0] tx_word;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sclk_a = 1'b0, csn_a = 1'b1, mosi_a = 1'b0, txv_a = 1'b0, rxr_a = 1'b0;
    logic [7:0]  txd_a = '0;
    logic        miso_a, txr_a, rxv_a, ovr_a, und_a, busy_a;
    logic [7:0]  rxd_a;

    logic        sclk_b = 1'b1, csn_b = 1'b1, mosi_b = 1'b0, txv_b = 1'b0, rxr_b = 1'b0;
    logic [15:0] txd_b = '0;
    logic        miso_b, txr_b, rxv_b, ovr_b, und_b, busy_b;
    logic [15:0] rxd_b;

    int n_cmp = 0;
    int n_bad = 0;

    spi_slave_stream #(.WIDTH(8), .RX_DEPTH(4), .CPOL(0), .CPHA(0)) dut_a (
        .clk(clk), .rst(rst), .spi_clk(sclk_a), .cs_n(csn_a), .mosi(mosi_a), .miso(miso_a),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(txr_a), .rx_data(rxd_a),
        .rx_valid(rxv_a), .rx_ready(rxr_a), .overrun(ovr_a), .underrun(und_a), .busy(busy_a)
    );

    spi_slave_stream #(.WIDTH(16), .RX_DEPTH(4), .CPOL(1), .CPHA(1)) dut_b (
        .clk(clk), .rst(rst), .spi_clk(sclk_b), .cs_n(csn_b), .mosi(mosi_b), .miso(miso_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(txr_b), .rx_data(rxd_b),
        .rx_valid(rxv_b), .rx_ready(rxr_b), .overrun(ovr_b), .underrun(und_b), .busy(busy_b)
    );

    task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checkw(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Wire position of bit i within a w-bit word.
    function automatic int bidx(input int i, input int w);
        int r;
        r = w - 1 - i;
`ifdef SPI_LSB_FIRST_EN
        r = i;
`endif
        return r;
    endfunction

    task automatic a_bit(input logic b, output logic m);
        mosi_a = b;
        #HALF;
        m = miso_a;
        sclk_a = 1'b1;
        #HALF;
        sclk_a = 1'b0;
    endtask

    task automatic b_bit(input logic b, output logic m);
        sclk_b = 1'b0;
        mosi_b = b;
        #HALF;
        m = miso_b;
        sclk_b = 1'b1;
        #HALF;
    endtask

    task automatic a_word(input logic [7:0] w, output logic [7:0] m);
        logic b;
        for (int i = 0; i < 8; i++) begin
            a_bit(w[bidx(i, 8)], b);
            m[bidx(i, 8)] = b;
        end
    endtask

    task automatic b_word(input logic [15:0] w, output logic [15:0] m);
        logic b;
        for (int i = 0; i < 16; i++) begin
            b_bit(w[bidx(i, 16)], b);
            m[bidx(i, 16)] = b;
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        @(negedge clk);
        txd_a = d;
        txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] d);
        @(negedge clk);
        txd_b = d;
        txv_b = 1'b1;
        @(negedge clk);
        txv_b = 1'b0;
    endtask

    task automatic pop_a(input string name, input logic [7:0] exp);
        check1({name, " rx_valid"}, rxv_a, 1'b1);
        checkw({name, " rx_data"}, {24'd0, rxd_a}, {24'd0, exp});
        @(negedge clk);
        rxr_a = 1'b1;
        @(negedge clk);
        rxr_a = 1'b0;
    endtask

    task automatic pop_b(input string name, input logic [15:0] exp);
        check1({name, " rx_valid"}, rxv_b, 1'b1);
        checkw({name, " rx_data"}, {16'd0, rxd_b}, {16'd0, exp});
        @(negedge clk);
        rxr_b = 1'b1;
        @(negedge clk);
        rxr_b = 1'b0;
    endtask

    task automatic end_frame_a();
        #HALF;
        csn_a = 1'b1;
        #(4 * HALF);
    endtask

    task automatic check_reset_a(input string name);
        check1({name, " miso"}, miso_a, 1'b0);
        check1({name, " tx_ready"}, txr_a, 1'b1);
        check1({name, " rx_valid"}, rxv_a, 1'b0);
        checkw({name, " rx_data"}, {24'd0, rxd_a}, 32'h0);
        check1({name, " overrun"}, ovr_a, 1'b0);
        check1({name, " underrun"}, und_a, 1'b0);
        check1({name, " busy"}, busy_a, 1'b0);
    endtask

    initial begin
        vec_t        vecs [4];
        logic [7:0]  m8, m8b, raw;
        logic [15:0] m16, m16b;
        logic        mb;

        vecs[0] = '{8'hCB, 8'hAB, 8'hCB, 8'hAB};
        vecs[1] = '{8'h5A, 8'h3C, 8'h5A, 8'h3C};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h01, 8'h80, 8'h01, 8'h80};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_reset_a("reset a");
        check1("reset b miso", miso_b, 1'b0);
        check1("reset b tx_ready", txr_b, 1'b1);
        check1("reset b rx_valid", rxv_b, 1'b0);
        check1("reset b busy", busy_b, 1'b0);

        // Mode 0 single-word frames
        for (int v = 0; v < 4; v++) begin
            push_a(vecs[v].tx_word);
            check1("tx_ready low after load", txr_a, 1'b0);
            csn_a = 1'b0;
            #HALF;
            a_bit(vecs[v].mosi_word[bidx(0, 8)], mb);
            m8 = '0;
            m8[bidx(0, 8)] = mb;
            check1("tx_ready after first bit", txr_a, 1'b1);
            check1("busy in frame", busy_a, 1'b1);
            for (int i = 1; i < 8; i++) begin
                a_bit(vecs[v].mosi_word[bidx(i, 8)], mb);
                m8[bidx(i, 8)] = mb;
            end
            end_frame_a();
            checkw("miso word", {24'd0, m8}, {24'd0, vecs[v].exp_miso});
            pop_a("vector", vecs[v].exp_rx);
            check1("rx_valid after pop", rxv_a, 1'b0);
            check1("busy after frame", busy_a, 1'b0);
        end

        // Two words back to back; second tx word loaded mid-word
        push_a(8'hAB);
        csn_a = 1'b0;
        #HALF;
        a_bit(8'hCB >> bidx(0, 8), mb);
        m8 = '0;
        m8[bidx(0, 8)] = mb;
        push_a(8'h3C);
        for (int i = 1; i < 8; i++) begin
            raw = 8'hCB;
            a_bit(raw[bidx(i, 8)], mb);
            m8[bidx(i, 8)] = mb;
        end
        a_word(8'hF0, m8b);
        end_frame_a();
        checkw("b2b miso word 1", {24'd0, m8}, 32'hAB);
        checkw("b2b miso word 2", {24'd0, m8b}, 32'h3C);
        check1("b2b overrun", ovr_a, 1'b0);
        pop_a("b2b first", 8'hCB);
        pop_a("b2b second", 8'hF0);
        check1("b2b drained", rxv_a, 1'b0);

        // Overrun: five words into a four-entry FIFO
        csn_a = 1'b0;
        #HALF;
        a_word(8'h11, m8);
        a_word(8'h22, m8);
        a_word(8'h33, m8);
        a_word(8'h44, m8);
        #HALF;
        check1("overrun before fifth", ovr_a, 1'b0);
        a_word(8'h55, m8);
        end_frame_a();
        check1("overrun set", ovr_a, 1'b1);
        pop_a("ovr 1", 8'h11);
        pop_a("ovr 2", 8'h22);
        pop_a("ovr 3", 8'h33);
        pop_a("ovr 4", 8'h44);
        check1("ovr fifth dropped", rxv_a, 1'b0);

        // Mode 3, 16-bit, second word with empty holding register
        push_b(16'hBEEF);
        check1("b tx_ready low after load", txr_b, 1'b0);
        csn_b = 1'b0;
        #HALF;
        b_word(16'h1234, m16);
        check1("b underrun after word 1", und_b, 1'b0);
        check1("b tx_ready after word 1", txr_b, 1'b1);
        b_word(16'h5678, m16b);
        #HALF;
        csn_b = 1'b1;
        #(4 * HALF);
        checkw("b miso word 1", {16'd0, m16}, 32'hBEEF);
        checkw("b miso word 2", {16'd0, m16b}, 32'h0);
        check1("b underrun", und_b, 1'b1);
        pop_b("b word 1", 16'h1234);
        pop_b("b word 2", 16'h5678);

        // Abort with no bits: held word survives
        push_a(8'h77);
        csn_a = 1'b0;
        #(2 * HALF);
        csn_a = 1'b1;
        #(4 * HALF);
        check1("empty abort keeps tx word", txr_a, 1'b0);
        check1("empty abort no rx", rxv_a, 1'b0);

        // Abort after 5 bits, then a full frame
        csn_a = 1'b0;
        #HALF;
        for (int i = 0; i < 5; i++) a_bit(1'b1, mb);
        end_frame_a();
        check1("abort no rx_valid", rxv_a, 1'b0);
        check1("abort consumed tx", txr_a, 1'b1);
        push_a(8'h96);
        csn_a = 1'b0;
        #HALF;
        a_word(8'h5A, m8);
        end_frame_a();
        checkw("after abort miso", {24'd0, m8}, 32'h96);
        pop_a("after abort", 8'h5A);

        // Raw wire bits for 0xCB in the configured bit order
`ifdef SPI_LSB_FIRST_EN
        raw = 8'b1101_0011;
`else
        raw = 8'b1100_1011;
`endif
        csn_a = 1'b0;
        #HALF;
        for (int i = 0; i < 8; i++) a_bit(raw[7 - i], mb);
        end_frame_a();
        pop_a("raw bits", 8'hCB);

        // Reset in the middle of a frame
        push_a(8'hAA);
        csn_a = 1'b0;
        #HALF;
        for (int i = 0; i < 3; i++) a_bit(1'b1, mb);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_a("mid-frame reset");
        for (int i = 0; i < 8; i++) a_bit(1'b1, mb);
        #(2 * HALF);
        check1("ignored frame rx_valid", rxv_a, 1'b0);
        check1("ignored frame busy", busy_a, 1'b0);
        check1("ignored frame underrun", und_a, 1'b0);
        end_frame_a();
        push_a(8'hC3);
        csn_a = 1'b0;
        #HALF;
        a_word(8'h3C, m8);
        end_frame_a();
        checkw("post reset miso", {24'd0, m8}, 32'hC3);
        pop_a("post reset", 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
- Parametrised SPI slave: generalises the fixed 8-bit, single-mode, unbuffered SPI reader.
- Adds configurable word width, all four CPOL/CPHA modes, an active-low chip select, a one-entry TX holding register with ready/valid, and an RX FIFO with ready/valid.
- Sits between the external SPI master pins and internal fabric logic; everything runs in the system clock domain.

Parameters:
- WIDTH, 8, bits per SPI word (2..32).
- RX_DEPTH, 4, RX FIFO entries (power of two, >= 2).
- CPOL, 0, idle level of spi_clk.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- spi_clk  in  1  SPI serial clock (asynchronous).
- cs_n  in  1  chip select, active low (asynchronous).
- mosi  in  1  master-out data (asynchronous).
- miso  out  1  slave-out data.
- tx_data  in  WIDTH  word to send on the next transfer.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX holding register empty.
- rx_data  out  WIDTH  head of RX FIFO.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready.
- overrun  out  1  sticky: a word was received while the FIFO was full.
- underrun  out  1  sticky: a word started with the TX holding register empty.
- busy  out  1  cs_n is asserted (synchronised).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: miso=0, tx_ready=1, rx_valid=0, rx_data=0, overrun=0, underrun=0, busy=0, bit counter=0, FIFO empty.
- Input synchronisation:
  - spi_clk, cs_n and mosi each pass through two flops; a third flop on spi_clk provides edge detection.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
  - spi_clk must be at most clk/8.
- Framing:
  - The frame starts on the synchronised cs_n falling edge; bit counter cleared.
  - A synchronised cs_n rising edge aborts the frame: partial RX bits are discarded, counter cleared, miso=0. The held TX word is not consumed if no bit was shifted.
- Bit order: MSB first. On each sample edge, shift_rx <= {shift_rx[WIDTH-2:0], mosi_sync}; counter += 1.
- Word completion:
  - On the sample edge that makes counter==WIDTH, the assembled word is pushed into the FIFO on the next clk and the counter wraps to 0.
  - rx_valid rises 1 clk after the push.
  - Consecutive words within one frame need no gap.
- RX FIFO:
  - A push while full drops the new word and sets overrun until rst.
  - Push and pop in the same cycle while full is not a drop: the pop frees the slot first.
- TX path:
  - Handshake: tx_valid && tx_ready loads the holding register; tx_ready falls the next cycle.
  - Word start: at cs_n fall (CPHA=0) or at the first shift edge (CPHA=1), and at every word boundary, the holding register moves to shift_tx and tx_ready rises the next cycle.
  - If the holding register is empty at word start, shift_tx=0 and underrun is set until rst.
  - miso = shift_tx[WIDTH-1] while cs_n is low, updated on each shift edge. For CPHA=0 the first bit is valid immediately after load.
- busy mirrors synchronised cs_n low.
- Reset while a frame is active: all state is cleared and the frame is ignored until cs_n goes high then low again.

Optional Feature:
- SPI_LSB_FIRST_EN defined: both shift registers run LSB first.
  - RX: shift right with mosi entering bit WIDTH-1.
  - TX: miso = shift_tx[0].
- Undefined: MSB first, as described above.

Decomposition:
- Package spi_pkg holds:
  - the spi_mode_t typedef ({cpol, cpha}),
  - an SPI_SYNC_STAGES=2 constant,
  - an edge-decode function returning sample/shift strobes from (prev, cur, CPOL, CPHA).
- One sub-module: spi_rx_fifo (synchronous FIFO, WIDTH x RX_DEPTH, ready/valid, full/empty, drop-on-full strobe).

Test Plan:
- Mode 0, WIDTH=8: tx preload 0xAB, send 0xCB MSB first -> rx_data=0xCB, miso stream 1,0,1,0,1,0,1,1, tx_ready=1 after first bit.
- Back-to-back in one frame: send 0xCB then 0xF0 with rx_ready=0 -> FIFO holds 0xCB, 0xF0 in order; popping yields both; overrun=0.
- Overrun, RX_DEPTH=4: send 5 words with rx_ready=0 -> overrun=1, FIFO contents = first 4 words, fifth dropped.
- Mode 3 (CPOL=1, CPHA=1), WIDTH=16: send 0x1234 with tx 0xBEEF -> rx_data=0x1234, miso serialises 0xBEEF; no tx loaded for second word -> underrun=1, miso=0.
- Abort: cs_n rises after 5 bits -> no rx_valid, counter cleared; next full frame 0x5A received correctly.
- SPI_LSB_FIRST_EN: mosi bits 1,1,0,1,0,0,1,1 -> rx_data=0xCB; rst mid-frame -> all outputs return to reset values.
